// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch stage: the fetch FSM state
// encoding, the PC step and the default address/instruction widths.
package if_pkg;

    localparam int          ADDR_W_DEF   = 64;
    localparam int          INSTR_W_DEF  = 32;
    localparam logic [63:0] RESET_PC_DEF = 64'h0;
    localparam int          PC_INCR      = 4;

    // FETCH: request on the bus
    // WAIT : one request outstanding
    // HOLD : output and skid both full
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry {pc, instr} holding register that catches a fetched word while
// the output register is still occupied by a stalled word.
// Ports: clk, rst_n (async, active-low), load/unload/flush controls,
//        in_pc/in_instr (captured on load), valid/out_pc/out_instr (held entry).
module if_skid_buffer
    import if_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               unload,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               valid,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr
);

    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    // Flush wins over load so a redirect never leaves a wrong-path word.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            instr_d = in_instr;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid     = valid_q;
    assign out_pc    = pc_q;
    assign out_instr = instr_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one imem request at a time, presents
// {PC_out, Instruction, if_valid} to IF/ID with a one-entry skid buffer
// for decode back-pressure, and flushes the wrong path on branch redirect.
// Ports: clk, reset (async, active-low); imem_req/imem_addr/imem_ready
//        request side; imem_rvalid/imem_rdata response side; PC_out,
//        Instruction, if_valid toward IF/ID; id_stall back-pressure;
//        branch_taken/branch_target redirect.
module instruction_fetch
    import if_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  PC_out,
    output logic [INSTR_W-1:0] Instruction,
    output logic               if_valid,
    input  logic               id_stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               req_q, req_d;
    logic               discard_q, discard_d;
    logic               out_valid_q, out_valid_d;
    logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;

    logic               skid_load, skid_unload, skid_flush;
    logic               skid_valid;
    logic [ADDR_W-1:0]  skid_pc;
    logic [INSTR_W-1:0] skid_instr;

    logic consume;
    logic accept;

    assign consume = out_valid_q & ~id_stall;
    assign accept  = req_q & imem_ready;

    if_skid_buffer #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (reset),
        .load      (skid_load),
        .unload    (skid_unload),
        .flush     (skid_flush),
        .in_pc     (pc_q),
        .in_instr  (imem_rdata),
        .valid     (skid_valid),
        .out_pc    (skid_pc),
        .out_instr (skid_instr)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        discard_d   = discard_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_flush  = 1'b0;

        if (branch_taken) begin
            // Redirect beats every other event this cycle.
            pc_d        = branch_target & ~ADDR_W'(2'b11);
            out_valid_d = 1'b0;
            skid_flush  = 1'b1;
            discard_d   = 1'b0;
            unique case (state_q)
                FETCH: begin
                    // A request accepted now still gets a response.
                    if (accept) begin
                        state_d   = WAIT;
                        discard_d = 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_d = FETCH;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                HOLD: state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end else begin
            if (consume) begin
                out_valid_d = 1'b0;
            end
            unique case (state_q)
                FETCH: begin
                    if (accept) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_d = FETCH;
                        if (discard_q) begin
                            discard_d = 1'b0;
                        end else begin
                            pc_d = pc_q + ADDR_W'(PC_INCR);
                            if (!out_valid_q || consume) begin
                                out_valid_d = 1'b1;
                                out_pc_d    = pc_q;
                                out_instr_d = imem_rdata;
                            end else begin
                                skid_load = 1'b1;
                                state_d   = HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (consume) begin
                        out_valid_d = skid_valid;
                        out_pc_d    = skid_pc;
                        out_instr_d = skid_instr;
                        skid_unload = 1'b1;
                        state_d     = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end

        // Registered request keeps imem_req low during reset.
        req_d = (state_d == FETCH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            req_q       <= 1'b0;
            discard_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_q       <= req_d;
            discard_q   <= discard_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign PC_out      = out_pc_q;
    assign Instruction = out_instr_q;
    assign if_valid    = out_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: memory model, in-order
// scoreboard of expected PCs, cycle table and redirect/reset sequences.
module tb_instruction_fetch;
    import if_pkg::*;

    localparam int AW = 64;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ready = 1'b0;
    logic          imem_rvalid = 1'b0;
    logic [IW-1:0] imem_rdata = '0;
    logic [AW-1:0] PC_out;
    logic [IW-1:0] Instruction;
    logic          if_valid;
    logic          id_stall = 1'b0;
    logic          branch_taken = 1'b0;
    logic [AW-1:0] branch_target = '0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .PC_out        (PC_out),
        .Instruction   (Instruction),
        .if_valid      (if_valid),
        .id_stall      (id_stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target)
    );

    int            errors = 0;
    int            checks = 0;
    logic [AW-1:0] exp_q[$];
    int            lat = 1;
    bit            rnd_ready = 1'b0;
    bit            mem_busy = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    int            mem_cnt = 0;
    bit            ok;

    typedef struct {
        bit            stall;
        bit            req;
        logic [AW-1:0] addr;
        bit            valid;
        logic [AW-1:0] pc;
    } vec_t;

    vec_t tbl[7];

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [AW-1:0] act,
                       input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic refill(input logic [AW-1:0] base);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(base + AW'(4 * i));
    endtask

    // One clock cycle: drive inputs at the falling edge, run the memory
    // model, and retire the presented word into the scoreboard if consumed.
    task automatic step(input bit stall, input bit br, input logic [AW-1:0] tgt);
        logic [AW-1:0] e;
        @(negedge clk);
        id_stall      = stall;
        branch_taken  = br;
        branch_target = tgt;
        imem_rvalid   = 1'b0;
        imem_rdata    = '0;
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_addr);
                mem_busy    = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        imem_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (imem_req && imem_ready) begin
            chk("one_outstanding", AW'(mem_busy), '0);
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = lat - 1;
        end
        if (if_valid && !stall) begin
            if (exp_q.size() == 0) begin
                timeout("sb_empty");
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", PC_out, e);
                chk("sb_instr", AW'(Instruction), AW'(mem_word(e)));
            end
        end
        if (br) refill(tgt & ~64'h3);
    endtask

    task automatic wait_accept(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b0, '0);
            if (imem_req && imem_ready) found = 1'b1;
        end
    endtask

    task automatic wait_valid(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b0, '0);
            if (if_valid) found = 1'b1;
        end
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 64'h0, 1'b0, 64'h0};
        tbl[1] = '{1'b0, 1'b0, 64'h0, 1'b0, 64'h0};
        tbl[2] = '{1'b0, 1'b1, 64'h4, 1'b1, 64'h0};
        tbl[3] = '{1'b0, 1'b0, 64'h4, 1'b0, 64'h0};
        tbl[4] = '{1'b0, 1'b1, 64'h8, 1'b1, 64'h4};
        tbl[5] = '{1'b0, 1'b0, 64'h8, 1'b0, 64'h4};
        tbl[6] = '{1'b0, 1'b1, 64'hC, 1'b1, 64'h8};

        repeat (3) @(negedge clk);
        chk("rst_pc_out", PC_out, '0);
        chk("rst_instr", AW'(Instruction), '0);
        chk("rst_valid", AW'(if_valid), '0);
        chk("rst_req", AW'(imem_req), '0);
        chk("rst_addr", imem_addr, '0);
        refill('0);
        reset = 1'b1;

        // Zero-wait memory, no stall: one word every two cycles.
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].stall, 1'b0, '0);
            chk($sformatf("tbl%0d_req", i), AW'(imem_req), AW'(tbl[i].req));
            chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), AW'(if_valid), AW'(tbl[i].valid));
            if (tbl[i].valid) chk($sformatf("tbl%0d_pc", i), PC_out, tbl[i].pc);
        end

        // Six stalled cycles: output holds 0xC, skid fills, FSM parks in HOLD.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, '0);
            if (i >= 1) chk("hold_pc", PC_out, 64'hC);
        end
        chk("hold_valid", AW'(if_valid), 64'h1);
        chk("hold_req", AW'(imem_req), '0);
        chk("hold_state", AW'(dut.state_q), AW'(HOLD));

        // Random ready, latency and stall; the scoreboard checks ordering.
        rnd_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            lat = $urandom_range(1, 3);
            step($urandom_range(0, 3) == 0, 1'b0, '0);
        end
        rnd_ready = 1'b0;
        lat = 1;
        repeat (6) step(1'b0, 1'b0, '0);

        // Redirect in WAIT; the in-flight response arrives later and is dropped.
        lat = 4;
        wait_accept(ok);
        if (!ok) timeout("br_wait_accept");
        step(1'b0, 1'b1, 64'h1003);
        step(1'b0, 1'b0, '0);
        chk("brw_valid", AW'(if_valid), '0);
        chk("brw_req", AW'(imem_req), '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        chk("brw_req2", AW'(imem_req), 64'h1);
        chk("brw_addr", imem_addr, 64'h1000);
        chk("brw_drop_valid", AW'(if_valid), '0);
        lat = 1;
        wait_valid(ok);
        if (!ok) timeout("brw_wait_valid");
        chk("brw_pc_out", PC_out, 64'h1000);
        chk("brw_instr", AW'(Instruction), AW'(mem_word(64'h1000)));

        // Redirect in the same cycle as the response.
        wait_accept(ok);
        if (!ok) timeout("brr_wait_accept");
        step(1'b0, 1'b1, 64'h2000);
        chk("brr_rvalid_seen", AW'(imem_rvalid), 64'h1);
        step(1'b0, 1'b0, '0);
        chk("brr_valid", AW'(if_valid), '0);
        chk("brr_req", AW'(imem_req), 64'h1);
        chk("brr_addr", imem_addr, 64'h2000);

        // PC wrap at the top of the address space.
        step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_valid(ok);
        if (!ok) timeout("wrap_wait_valid");
        chk("wrap_pc_out", PC_out, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_req", AW'(imem_req), 64'h1);
        chk("wrap_addr", imem_addr, '0);

        // Asynchronous reset with both buffers full, then a stray response.
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step(1'b1, 1'b0, '0);
            if (dut.state_q == HOLD) ok = 1'b1;
        end
        if (!ok) timeout("rst_wait_hold");
        chk("pre_rst_valid", AW'(if_valid), 64'h1);
        #2 reset = 1'b0;
        #1;
        chk("arst_pc_out", PC_out, '0);
        chk("arst_instr", AW'(Instruction), '0);
        chk("arst_valid", AW'(if_valid), '0);
        chk("arst_req", AW'(imem_req), '0);
        chk("arst_addr", imem_addr, '0);
        mem_busy = 1'b0;
        id_stall = 1'b0;
        @(negedge clk);
        reset       = 1'b1;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        refill('0);
        step(1'b0, 1'b0, '0);
        chk("stray_valid", AW'(if_valid), '0);
        chk("stray_req", AW'(imem_req), 64'h1);
        wait_valid(ok);
        if (!ok) timeout("post_rst_wait_valid");
        chk("post_rst_pc", PC_out, '0);
        chk("post_rst_instr", AW'(Instruction), AW'(mem_word(64'h0)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
